rv_int_alu_seq: RTL and testbench

Parametrised, handshaked successor of the single-cycle I-type datapath. Executes all RV32I/RV64I OP-IMM and OP integer operations (add/sub, slt/sltu, xor/or/and, sll/srl/sra). Non-shift operations take one cycle. Shifts use an iterative shifter sized by a parameter, so area can be traded for latency. Sits between decode/register-read and writeback, with valid/ready on both sides.

---
 rtl/rv_int_alu_seq_if.sv | 29 ++
 rtl/rv_int_alu_seq.sv | 79 +++++++
 tb/tb_rv_int_alu_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rv_int_alu_seq_if.sv
// Handshake bundle for rv_int_alu_seq: the issue side (valid/ready + operands)
// and the writeback side (valid/ready + result).
interface rv_int_alu_seq_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             is_rtype;
  logic [2:0]       funct3;
  logic             funct7_b30;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output in_valid, is_rtype, funct3, funct7_b30, rs1_val, op_b, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, busy
  );
  modport slave (
    input  in_valid, is_rtype, funct3, funct7_b30, rs1_val, op_b, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, busy
  );
endinterface

// File: rtl/rv_int_alu_seq.sv
// RV32I/RV64I OP / OP-IMM integer ALU with valid/ready handshakes on both sides.
// Non-shift ops take one cycle; shifts iterate SHIFT_STEP bit positions per cycle.
module rv_int_alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int TAG_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  rv_int_alu_seq_if.slave io
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shop_t;

  state_t           state;
  shop_t            shop;
  logic [XLEN-1:0]  res_q;
  logic [TAG_W-1:0] tag_q;
  logic [SW-1:0]    rem_q;

  logic             accept, is_shift;
  logic [SW-1:0]    shamt, k;
  logic [XLEN-1:0]  alu;

  assign io.in_ready  = (state == IDLE) || (state == HOLD && io.out_ready);
  assign io.out_valid = (state == HOLD);
  assign io.busy      = (state == SHIFT);
  assign io.result    = res_q;
  assign io.tag_out   = tag_q;

  assign accept   = io.in_valid && io.in_ready;
  assign shamt    = io.op_b[SW-1:0];
  assign is_shift = (io.funct3 == 3'b001) || (io.funct3 == 3'b101);

  always_comb begin
    alu = '0;
    case (io.funct3)
      3'b000:  alu = (io.is_rtype && io.funct7_b30) ? io.rs1_val - io.op_b
                                                    : io.rs1_val + io.op_b;
      3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(io.rs1_val) < $signed(io.op_b)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, io.rs1_val < io.op_b};
      3'b100:  alu = io.rs1_val ^ io.op_b;
      3'b110:  alu = io.rs1_val | io.op_b;
      3'b111:  alu = io.rs1_val & io.op_b;
      default: alu = io.rs1_val;  // shifts start from rs1 and iterate in SHIFT
    endcase
  end

  // remaining < XLEN, so when SHIFT_STEP >= XLEN the first branch never fires
  assign k = (int'(rem_q) > SHIFT_STEP) ? SW'(SHIFT_STEP) : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shop  <= SH_SLL;
      res_q <= '0;
      tag_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      tag_q <= io.tag_in;
      res_q <= alu;
      rem_q <= shamt;
      shop  <= (io.funct3 == 3'b001) ? SH_SLL : (io.funct7_b30 ? SH_SRA : SH_SRL);
      state <= (is_shift && shamt != '0) ? SHIFT : HOLD;
    end else if (state == HOLD && io.out_ready) begin
      state <= IDLE;
    end else if (state == SHIFT) begin
      case (shop)
        SH_SLL:  res_q <= res_q << k;
        SH_SRL:  res_q <= res_q >> k;
        default: res_q <= $signed(res_q) >>> k;  // MSB never changes, so it is the original sign
      endcase
      rem_q <= rem_q - k;
      if (rem_q == k) state <= HOLD;
    end
  end
endmodule

// File: tb/tb_rv_int_alu_seq.sv
// Directed bench for rv_int_alu_seq: three instances (SHIFT_STEP = 1, 8, XLEN)
// share one stimulus stream; outputs are compared to hand-computed values.
module tb_rv_int_alu_seq;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, is_rtype = 0, funct7_b30 = 0, out_ready = 1;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0, op_b = '0;
  logic [4:0]  tag_in = '0;

  logic [2:0]  ov, ir, bz;
  logic [31:0] rs [3];
  logic [4:0]  tg [3];

  int n_chk = 0, n_fail = 0;
  int lat [3];
  logic [31:0] rres [3];
  logic [4:0]  rtag [3];
  int busy_cnt, irdy_bad;

  always #5 clk = ~clk;

  rv_int_alu_seq_if #(.XLEN(32), .TAG_W(5)) if1 (), if8 (), ifx ();

  assign if1.in_valid = in_valid, if1.is_rtype = is_rtype, if1.funct3 = funct3,
         if1.funct7_b30 = funct7_b30, if1.rs1_val = rs1_val, if1.op_b = op_b,
         if1.tag_in = tag_in, if1.out_ready = out_ready;
  assign if8.in_valid = in_valid, if8.is_rtype = is_rtype, if8.funct3 = funct3,
         if8.funct7_b30 = funct7_b30, if8.rs1_val = rs1_val, if8.op_b = op_b,
         if8.tag_in = tag_in, if8.out_ready = out_ready;
  assign ifx.in_valid = in_valid, ifx.is_rtype = is_rtype, ifx.funct3 = funct3,
         ifx.funct7_b30 = funct7_b30, ifx.rs1_val = rs1_val, ifx.op_b = op_b,
         ifx.tag_in = tag_in, ifx.out_ready = out_ready;

  assign ov = {ifx.out_valid, if8.out_valid, if1.out_valid};
  assign ir = {ifx.in_ready,  if8.in_ready,  if1.in_ready};
  assign bz = {ifx.busy,      if8.busy,      if1.busy};
  assign rs[0] = if1.result;  assign rs[1] = if8.result;  assign rs[2] = ifx.result;
  assign tg[0] = if1.tag_out; assign tg[1] = if8.tag_out; assign tg[2] = ifx.tag_out;

  rv_int_alu_seq #(.XLEN(32), .SHIFT_STEP(1),  .TAG_W(5)) u1 (.clk(clk), .rst_n(rst_n), .io(if1));
  rv_int_alu_seq #(.XLEN(32), .SHIFT_STEP(8),  .TAG_W(5)) u8 (.clk(clk), .rst_n(rst_n), .io(if8));
  rv_int_alu_seq #(.XLEN(32), .SHIFT_STEP(32), .TAG_W(5)) ux (.clk(clk), .rst_n(rst_n), .io(ifx));

  typedef struct {
    logic        r;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input logic r, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    is_rtype = r; funct3 = f3; funct7_b30 = f7; rs1_val = a; op_b = b; tag_in = t;
    in_valid = 1;
  endtask

  // Presents one op (called #1 after an edge, all instances ready) and records,
  // per instance, the cycle on which out_valid first rises; 0 means it never did.
  task automatic run_op(input logic r, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bit done [3];
    set_op(r, f3, f7, a, b, t);
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; done[i] = 0; rres[i] = 'x; rtag[i] = 'x; end
    busy_cnt = 0; irdy_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      for (int i = 0; i < 3; i++)
        if (!done[i] && ov[i]) begin done[i] = 1; lat[i] = c; rres[i] = rs[i]; rtag[i] = tg[i]; end
      if (bz[0]) busy_cnt++;
      if (!done[0] && ir[0]) irdy_bad++;
      if (done[0] && done[1] && done[2]) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vt[0]  = '{0, 3'd0, 0, 32'hFFFF_FFF0, 32'h10, 32'h0000_0000};  // addi
    vt[1]  = '{1, 3'd0, 1, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0};  // sub
    vt[2]  = '{0, 3'd0, 1, 32'hFFFF_FFF0, 32'h10, 32'h0000_0000};  // addi, b30 ignored
    vt[3]  = '{1, 3'd2, 0, 32'hFFFF_FFF0, 32'h10, 32'h0000_0001};  // slt
    vt[4]  = '{1, 3'd3, 0, 32'hFFFF_FFF0, 32'h10, 32'h0000_0000};  // sltu
    vt[5]  = '{0, 3'd4, 1, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0};  // xori, b30 ignored
    vt[6]  = '{1, 3'd6, 0, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFF0};  // or
    vt[7]  = '{1, 3'd7, 0, 32'hFFFF_FFF0, 32'h10, 32'h0000_0010};  // and
    vt[8]  = '{0, 3'd3, 0, 32'h5, 32'hFFFF_FFFF, 32'h1};           // sltiu vs -1 as unsigned
    vt[9]  = '{0, 3'd2, 0, 32'h5, 32'hFFFF_FFFF, 32'h0};           // slti vs -1
    vt[10] = '{0, 3'd1, 0, 32'h1234_5678, 32'h20, 32'h1234_5678};  // slli shamt=0 (bit 5 ignored)
    vt[11] = '{1, 3'd0, 1, 32'h0, 32'h1, 32'hFFFF_FFFF};           // sub wraps

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_result",    rs[0], 0);
    chk("rst_in_ready",  32'(ir[0]), 1);
    chk("rst_busy",      32'(bz[0]), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // single-cycle ALU ops, every instance latency 1
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].r, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, 5'(i));
      chk($sformatf("vec%0d_result", i), rres[0], vt[i].exp);
      chk($sformatf("vec%0d_tag", i), 32'(rtag[0]), 32'(i));
      for (int j = 0; j < 3; j++) chk($sformatf("vec%0d_lat_inst%0d", i, j), lat[j], 1);
    end

    // sra / srl by 4, STEP=1 takes 1+4 cycles
    run_op(1, 3'd5, 1, 32'h8000_0000, 32'd4, 5'd20);
    chk("sra_result", rres[0], 32'hF800_0000);
    chk("sra_latency", lat[0], 5);
    chk("sra_busy_cycles", busy_cnt, 4);
    chk("sra_in_ready_low", irdy_bad, 0);
    chk("sra_step8_result", rres[1], 32'hF800_0000);
    chk("sra_step8_latency", lat[1], 2);
    run_op(0, 3'd5, 0, 32'h8000_0000, 32'd4, 5'd21);
    chk("srl_result", rres[0], 32'h0800_0000);
    chk("srl_latency", lat[0], 5);
    chk("srl_stepx_result", rres[2], 32'h0800_0000);

    // sll 1 by 31 across step sizes
    run_op(0, 3'd1, 0, 32'h1, 32'd31, 5'd22);
    chk("sll31_step1_lat", lat[0], 32);
    chk("sll31_step8_lat", lat[1], 5);
    chk("sll31_stepx_lat", lat[2], 2);
    for (int j = 0; j < 3; j++) chk($sformatf("sll31_result_inst%0d", j), rres[j], 32'h8000_0000);
    @(posedge clk); #1;

    // backpressure: result/tag held, in_ready low, then same-cycle re-accept
    out_ready = 0;
    set_op(1, 3'd4, 0, 32'hA5A5_0000, 32'h0000_5A5A, 5'd9);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_out_valid", 32'(ov[0]), 1);
    for (int c = 0; c < 3; c++) begin
      chk("bp_result_held", rs[0], 32'hA5A5_5A5A);
      chk("bp_tag_held", 32'(tg[0]), 9);
      chk("bp_in_ready_low", 32'(ir[0]), 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    set_op(0, 3'd0, 0, 32'd1, 32'd2, 5'd3);
    #1;
    chk("bp_in_ready_release", 32'(ir[0]), 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_next_valid", 32'(ov[0]), 1);
    chk("bp_next_result", rs[0], 32'd3);
    chk("bp_next_tag", 32'(tg[0]), 3);
    @(posedge clk); #1;

    // throughput: 8 back-to-back adds
    for (int i = 0; i < 8; i++) begin
      set_op(0, 3'd0, 0, 32'(i), 32'd100, 5'(i));
      @(posedge clk); #1;
      chk($sformatf("tp%0d_valid", i), 32'(ov[0]), 1);
      chk($sformatf("tp%0d_tag", i), 32'(tg[0]), 32'(i));
      chk($sformatf("tp%0d_result", i), rs[0], 32'(100 + i));
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("tp_drain_idle", 32'(ov[0]), 0);

    // reset mid-SHIFT discards the op
    set_op(0, 3'd1, 0, 32'h1, 32'd20, 5'd7);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("midshift_busy", 32'(bz[0]), 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("midshift_rst_result", rs[0], 0);
    rst_n = 1;
    begin
      int seen = 0;
      for (int c = 0; c < 30; c++) begin
        if (ov[0]) seen++;
        @(posedge clk); #1;
      end
      chk("midshift_no_output", seen, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
